// File: rtl/compare_sar_search.sv
// Successive-approximation search controller. Drives probe values into an
// external magnitude comparator and resolves the comparator's B operand one
// bit at a time, MSB first, with an early exit on an exact match.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for Start; DataA parked at 0
//   PROBE  | probe held on DataA, settle counter running, flags sampled at 0
//   FINISH | one-cycle Done pulse; Result/Error already valid
module compare_sar_search #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  output logic [WIDTH-1:0] DataA,
  input  logic             QAEB,
  input  logic             QAGB,
  input  logic             QASB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Error
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PROBE  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] probe;
  logic [WIDTH-1:0] trial_next;

  // Current probe is the bits resolved so far plus the bit under test.
  assign mask       = {{(WIDTH-1){1'b0}}, 1'b1} << bit_q;
  assign probe      = trial_q | mask;
  // Probe below target means the tested bit belongs to the answer.
  assign trial_next = QASB ? probe : trial_q;

  // Next-state and datapath decisions; everything holds unless updated.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    trial_d  = trial_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_PROBE;
          bit_d   = IW'(WIDTH - 1);
          trial_d = '0;
          cnt_d   = 4'(SETTLE);
          error_d = 1'b0;
        end
      end
      S_PROBE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          case ({QAEB, QAGB, QASB})
            3'b100: begin
              result_d = probe;
              state_d  = S_FINISH;
            end
            3'b010, 3'b001: begin
              if (bit_q == '0) begin
                result_d = trial_next;
                state_d  = S_FINISH;
              end else begin
                trial_d = trial_next;
                bit_d   = bit_q - IW'(1);
                cnt_d   = 4'(SETTLE);
              end
            end
            default: begin
              // No flag or conflicting flags: the comparator cannot be trusted.
              error_d  = 1'b1;
              result_d = '0;
              state_d  = S_FINISH;
            end
          endcase
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      bit_q    <= '0;
      trial_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
    end
  end

  assign Busy   = (state_q == S_PROBE);
  assign Done   = (state_q == S_FINISH);
  assign DataA  = Busy ? probe : '0;
  assign Result = result_q;
  assign Error  = error_q;

endmodule

// File: tb/tb_compare_sar_search.sv
// Randomized bench for compare_sar_search with a behavioural comparator and
// an arithmetic reference model of the expected probe sequence.
module tb_compare_sar_search;

  localparam int W = 8;
  localparam int S = 1;

  logic         CLK;
  logic         RST;
  logic         Start;
  logic [W-1:0] DataA;
  logic         QAEB, QAGB, QASB;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;
  logic         Error;

  logic [W-1:0] target;
  int           flag_mode;   // 0 honest, 1 no flags, 2 all flags, 3 GT+LT

  int checks = 0;
  int errors = 0;

  int exp_p[W];
  int exp_n;
  int exp_res;
  int exp_err;

  compare_sar_search #(.WIDTH(W), .SETTLE(S)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Start  (Start),
    .DataA  (DataA),
    .QAEB   (QAEB),
    .QAGB   (QAGB),
    .QASB   (QASB),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .Error  (Error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Comparator under bench control.
  always_comb begin
    QAEB = 1'b0;
    QAGB = 1'b0;
    QASB = 1'b0;
    case (flag_mode)
      0: begin
        QAEB = (DataA == target);
        QAGB = (DataA > target);
        QASB = (DataA < target);
      end
      1: ;
      2: begin
        QAEB = 1'b1;
        QAGB = 1'b1;
        QASB = 1'b1;
      end
      default: begin
        QAGB = 1'b1;
        QASB = 1'b1;
      end
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t target=0x%0h)",
               tag, obs, exp, $time, target);
    end
  endtask

  // Probe j keeps the target's bits above the bit under test and sets that bit;
  // the search stops at the first probe that equals the target.
  task automatic model(input int t, input int mode);
    for (int j = 0; j < W; j++) exp_p[j] = 0;
    if (mode != 0) begin
      exp_p[0] = 1 << (W - 1);
      exp_n    = 1;
      exp_res  = 0;
      exp_err  = 1;
    end else begin
      exp_n = W;
      for (int j = 0; j < W; j++) begin
        int hi_mask;
        int p;
        hi_mask  = ((1 << W) - 1) & ~(((1 << W) - 1) >> j);
        p        = (t & hi_mask) | ((1 << (W - 1)) >> j);
        exp_p[j] = p;
        if (p == t) begin
          exp_n = j + 1;
          break;
        end
      end
      exp_res = t;
      exp_err = 0;
    end
  endtask

  // pulse_at: -1 none, -2 random, otherwise cycle offset of an extra Start.
  task automatic do_search(input int t, input int mode, input int pulse_at);
    int  lat;
    int  pulse;
    bit  got_done;
    model(t, mode);
    lat = exp_n * (S + 1);
    pulse = pulse_at;
    if (pulse == -2) pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, lat - 1)) : -1;
    target    = W'(t);
    flag_mode = mode;
    @(negedge CLK);
    Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c <= 4 * W * (S + 1) && !got_done; c++) begin
      @(negedge CLK);
      if (c == 0) check("err_clr_on_start", int'(Error), 0);
      if (Done) begin
        got_done = 1'b1;
        check("done_latency", c, lat);
        check("result", int'(Result), exp_res);
        check("error", int'(Error), exp_err);
        check("finish_dataa", int'(DataA), 0);
        check("finish_busy", int'(Busy), 0);
      end else if (c < lat) begin
        check("busy", int'(Busy), 1);
        check("probe", int'(DataA), exp_p[c / (S + 1)]);
      end
      Start = (c == pulse);
    end
    Start = 1'b0;
    if (!got_done) check("done_timeout", 0, 1);
    @(negedge CLK);
    check("done_one_cycle", int'(Done), 0);
    check("start_not_queued", int'(Busy), 0);
    check("result_held", int'(Result), exp_res);
    check("error_held", int'(Error), exp_err);
    check("idle_dataa", int'(DataA), 0);
    flag_mode = 0;
  endtask

  // RST lands on edge k+6 of a search; nothing may pulse Done.
  task automatic reset_mid(input int t);
    target    = W'(t);
    flag_mode = 0;
    @(negedge CLK);
    Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge CLK);
      check("rst_no_done_before", int'(Done), 0);
    end
    RST = 1'b1;
    @(negedge CLK);
    check("rst_busy", int'(Busy), 0);
    check("rst_dataa", int'(DataA), 0);
    check("rst_result", int'(Result), 0);
    check("rst_done", int'(Done), 0);
    check("rst_error", int'(Error), 0);
    RST = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    Start     = 1'b0;
    flag_mode = 0;
    target    = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_dataa", int'(DataA), 0);
    check("reset_busy", int'(Busy), 0);
    check("reset_done", int'(Done), 0);
    check("reset_result", int'(Result), 0);
    check("reset_error", int'(Error), 0);
    RST = 1'b0;

    do_search(8'h5A, 0, -1);
    do_search(8'h00, 0, -1);
    do_search(8'hFF, 0, -1);
    do_search(8'h80, 0, -1);
    do_search(8'h33, 0, 4);
    do_search(8'h5A, 1, -1);
    do_search(8'h5A, 0, -1);
    do_search(8'h21, 2, -1);
    do_search(8'h21, 3, 0);
    reset_mid(8'h5A);
    do_search(8'h5A, 0, -1);

    for (int it = 0; it < 40; it++) begin
      int r;
      int m;
      r = int'($urandom_range(0, 9));
      m = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
      do_search(int'($urandom_range(0, (1 << W) - 1)), m, -2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
